rf_fifo_ctrl: RTL and testbench

// - Single-clock FIFO controller that drives the write and read ports of rf_1r1w_wrapper.
// - Issues the RF init sequence after reset, maps a push valid/ready stream onto RF writes and RF reads onto a pop valid/ready stream.
// - Absorbs the RF read latency with a credit-controlled skid buffer, so pop never stalls a read already in flight.
// - Connect both RF clock domains to clk and both RF resets to ~rst.

---
 rtl/rf_fifo_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rf_fifo_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_fifo_ctrl.sv
// FIFO controller driving the write/read ports of a 1R1W register file, with a credit-based skid buffer
// absorbing RF read latency. Define RF_FIFO_CTRL_ERR_CHK_EN to add sticky err_ovf/err_udf outputs.
module rf_fifo_ctrl #(
    parameter int READ_DELAY = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int RF_DEPTH   = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  init_busy,
    output logic                  rf_init_start,
    input  logic                  rf_init_done,
    output logic                  rf_we_n,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_rd_n,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
`ifdef RF_FIFO_CTRL_ERR_CHK_EN
    output logic                  err_ovf,
    output logic                  err_udf,
`endif
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

    localparam int SKID_DEPTH = READ_DELAY + 1;
    localparam int SKW        = $clog2(SKID_DEPTH);
    localparam int SCW        = $clog2(SKID_DEPTH + 1);
    localparam int CW         = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RF_DEPTH - 1);
    localparam logic [CW-1:0]         DEPTH_CNT = CW'(RF_DEPTH);
    localparam logic [SKW-1:0]        LAST_SKID = SKW'(SKID_DEPTH - 1);

    typedef enum logic [1:0] {INIT_REQ, INIT_WAIT, RUN} state_e;

    state_e                  state_q;
    logic                    init_start_q, init_busy_q;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           ram_cnt_q, ram_cnt_d;
    logic [READ_DELAY-1:0]   rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0]   skid_mem_q [SKID_DEPTH];
    logic [SKW-1:0]          skid_wr_q, skid_wr_d, skid_rd_q, skid_rd_d;
    logic [SCW-1:0]          skid_cnt_q, skid_cnt_d;
    logic [SCW-1:0]          inflight;
    logic                    run, act, clr, push, pop, rd_issue, capture, credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT_REQ;
            init_start_q <= 1'b0;
            init_busy_q  <= 1'b1;
        end else begin
            case (state_q)
                INIT_REQ: begin
                    init_start_q <= 1'b1;
                    state_q      <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    init_start_q <= 1'b0;
                    if (rf_init_done && !init_start_q) begin
                        state_q     <= RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign run     = (state_q == RUN);
    assign clr     = run && flush;
    assign act     = run && !flush;
    assign capture = rd_vld_q[READ_DELAY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_DELAY; i++) inflight = inflight + SCW'(rd_vld_q[i]);
    end

    // A pop this cycle frees a slot, so it counts as credit; this keeps 1 read/cycle sustained.
    assign credit_ok = (int'(skid_cnt_q) + int'(inflight)) < (SKID_DEPTH + int'(pop));
    assign in_ready  = act && (ram_cnt_q < DEPTH_CNT);
    assign push      = in_valid && in_ready;
    assign out_valid = act && (skid_cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign rd_issue  = act && (ram_cnt_q != '0) && credit_ok;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        ram_cnt_d  = ram_cnt_q;
        rd_vld_d   = READ_DELAY'({rd_vld_q, rd_issue});
        skid_wr_d  = skid_wr_q;
        skid_rd_d  = skid_rd_q;
        skid_cnt_d = skid_cnt_q;
        if (clr) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            rd_vld_d   = '0;
            skid_wr_d  = '0;
            skid_rd_d  = '0;
            skid_cnt_d = '0;
        end else begin
            if (push)     wptr_d    = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_WIDTH'(1);
            if (rd_issue) rptr_d    = (rptr_q == LAST_ADDR) ? '0 : rptr_q + ADDR_WIDTH'(1);
            if (capture)  skid_wr_d = (skid_wr_q == LAST_SKID) ? '0 : skid_wr_q + SKW'(1);
            if (pop)      skid_rd_d = (skid_rd_q == LAST_SKID) ? '0 : skid_rd_q + SKW'(1);
            ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(rd_issue);
            skid_cnt_d = skid_cnt_q + SCW'(capture) - SCW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            rd_vld_q   <= '0;
            skid_wr_q  <= '0;
            skid_rd_q  <= '0;
            skid_cnt_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) skid_mem_q[i] <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            rd_vld_q   <= rd_vld_d;
            skid_wr_q  <= skid_wr_d;
            skid_rd_q  <= skid_rd_d;
            skid_cnt_q <= skid_cnt_d;
            // Returning data is dropped when a flush lands on its capture edge.
            if (capture && !clr) skid_mem_q[skid_wr_q] <= rf_rdata;
        end
    end

    assign out_data      = skid_mem_q[skid_rd_q];
    assign level         = ram_cnt_q + CW'(inflight) + CW'(skid_cnt_q);
    assign init_busy     = init_busy_q;
    assign rf_init_start = init_start_q;
    assign rf_we_n       = !push;
    assign rf_waddr      = wptr_q;
    assign rf_wdata      = push ? in_data : '0;
    assign rf_rd_n       = !rd_issue;
    assign rf_raddr      = rptr_q;

`ifdef RF_FIFO_CTRL_ERR_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (clr) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (run) begin
            if (in_valid && !in_ready)  err_ovf <= 1'b1;
            if (out_ready && !out_valid) err_udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Bench for rf_fifo_ctrl: READ_DELAY=1 and READ_DELAY=2 instances side by side, each with a behavioural
// RF model and a queue scoreboard, plus vector tables and hand-written corner sequences.
module tb_rf_fifo_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [1:0] in_ready_w, out_valid_w, init_busy_w, init_start_w, init_done_w, we_n_w, rd_n_w;
    logic [1:0][DW-1:0] out_data_w, wdata_w;
    logic [1:0][AW:0]   level_w;
    logic [1:0][AW-1:0] waddr_w, raddr_w;
`ifdef RF_FIFO_CTRL_ERR_CHK_EN
    logic [1:0] err_ovf_w, err_udf_w;
`endif
    int  total = 0, bad = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        logic          done_q;
        int            icnt;
        logic [DW-1:0] mem [16];
        logic [DW-1:0] s1_q, s2_q;
        logic [DW-1:0] sb[$];

        rf_fifo_ctrl #(.READ_DELAY(g + 1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready_w[g]), .in_data(in_data),
            .out_valid(out_valid_w[g]), .out_ready(out_ready), .out_data(out_data_w[g]),
            .level(level_w[g]), .init_busy(init_busy_w[g]),
            .rf_init_start(init_start_w[g]), .rf_init_done(done_q),
            .rf_we_n(we_n_w[g]), .rf_waddr(waddr_w[g]), .rf_wdata(wdata_w[g]),
            .rf_rd_n(rd_n_w[g]), .rf_raddr(raddr_w[g]),
`ifdef RF_FIFO_CTRL_ERR_CHK_EN
            .err_ovf(err_ovf_w[g]), .err_udf(err_udf_w[g]),
`endif
            .rf_rdata((g == 0) ? s1_q : s2_q));

        assign init_done_w[g] = done_q;

        // RF model: init completes a fixed 16 cycles after the start pulse; reads return after g+1 edges.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                icnt   <= 0;
                done_q <= 1'b0;
            end else begin
                if (init_start_w[g]) icnt <= 1;
                else if (icnt > 0 && icnt < 16) icnt <= icnt + 1;
                if (icnt == 15) done_q <= 1'b1;
            end
        end

        always @(posedge clk) begin
            if (!we_n_w[g]) mem[waddr_w[g]] <= wdata_w[g];
            if (!rd_n_w[g]) s1_q <= mem[raddr_w[g]];
            s2_q <= s1_q;
        end

        // Scoreboard: every accepted word is held somewhere until popped, in order.
        always @(negedge clk) begin
            if (!mon_en) sb.delete();
            else begin
                chk($sformatf("level_vs_model[%0d]", g), int'(level_w[g]), sb.size());
                if (level_w[g] == 0) begin
                    chk($sformatf("empty_out_valid[%0d]", g), int'(out_valid_w[g]), 0);
                    chk($sformatf("empty_rd_n[%0d]", g), int'(rd_n_w[g]), 1);
                end
                if (flush) begin
                    chk($sformatf("flush_in_ready[%0d]", g), int'(in_ready_w[g]), 0);
                    chk($sformatf("flush_out_valid[%0d]", g), int'(out_valid_w[g]), 0);
                end else if (int'(level_w[g]) < 16)
                    chk($sformatf("not_full_in_ready[%0d]", g), int'(in_ready_w[g]), 1);
                if (out_valid_w[g] && out_ready) begin
                    if (sb.size() == 0) chk($sformatf("pop_from_empty[%0d]", g), 1, 0);
                    else begin
                        chk($sformatf("pop_data[%0d]", g), int'(out_data_w[g]), int'(sb[0]));
                        void'(sb.pop_front());
                    end
                end
                if (in_valid && in_ready_w[g]) sb.push_back(in_data);
                if (flush) sb.delete();
            end
        end
    end

    typedef struct {
        logic iv; logic [DW-1:0] d; logic orr;
        logic ov1; int l1; logic [DW-1:0] d1;
        logic ov2; int l2; logic [DW-1:0] d2;
        logic rdn;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic ov1, input int l1,
                                input logic [DW-1:0] d1, input logic ov2, input int l2,
                                input logic [DW-1:0] d2, input logic rdn);
        vec_t v;
        v.iv = iv; v.d = d; v.orr = 1'b1;
        v.ov1 = ov1; v.l1 = l1; v.d1 = d1;
        v.ov2 = ov2; v.l2 = l2; v.d2 = d2;
        v.rdn = rdn;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_in_ready"},   int'(in_ready_w), 0);
        chk({tag, "_out_valid"},  int'(out_valid_w), 0);
        chk({tag, "_out_data"},   int'(out_data_w), 0);
        chk({tag, "_level"},      int'(level_w), 0);
        chk({tag, "_init_busy"},  int'(init_busy_w), 3);
        chk({tag, "_init_start"}, int'(init_start_w), 0);
        chk({tag, "_we_n"},       int'(we_n_w), 3);
        chk({tag, "_rd_n"},       int'(rd_n_w), 3);
        chk({tag, "_waddr"},      int'(waddr_w), 0);
        chk({tag, "_raddr"},      int'(raddr_w), 0);
        chk({tag, "_wdata"},      int'(wdata_w), 0);
    endtask

    // Called in the drive phase right after reset release; returns in the drive phase.
    task automatic run_init();
        int st0 = 0, st1 = 0, first = -1;
        bit ok = 1'b0;
        logic [1:0] prev_done = 2'b00;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            st0 += int'(init_start_w[0]);
            st1 += int'(init_start_w[1]);
            if (init_start_w[0] && first < 0) first = n;
            if (prev_done == 2'b11) begin
                chk("init_in_ready_after_done", int'(in_ready_w), 3);
                chk("init_busy_after_done", int'(init_busy_w), 0);
                ok = 1'b1;
                break;
            end
            if (n < 3 || n[2:0] == 0) chk("init_in_ready_low", int'(in_ready_w), 0);
            prev_done = init_done_w;
            @(posedge clk);
            #1;
        end
        chk("init_timeout", int'(ok), 1);
        chk("init_start_pulses0", st0, 1);
        chk("init_start_pulses1", st1, 1);
        chk("init_start_early", int'(first >= 0 && first <= 1), 1);
        if (ok) cyc();
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (level_w == '0) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        chk({tag, "_drain_timeout"}, int'(ok), 1);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen[2];
        #1 rst = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        rst_chk("reset");
        cyc();
        rst = 1'b0;
        run_init();
        mon_en = 1'b1;

        // Single word and back-to-back pair: exact per-cycle latency for RD=1 and RD=2.
        tbl.push_back(mk(1, 16'hA5A5, 0, 0, 0,          0, 0, 0,          1));
        tbl.push_back(mk(0, 0,        0, 1, 0,          0, 1, 0,          0));
        tbl.push_back(mk(0, 0,        0, 1, 0,          0, 1, 0,          1));
        tbl.push_back(mk(0, 0,        1, 1, 16'hA5A5,   0, 1, 0,          1));
        tbl.push_back(mk(0, 0,        0, 0, 0,          1, 1, 16'hA5A5,   1));
        tbl.push_back(mk(0, 0,        0, 0, 0,          0, 0, 0,          1));
        tbl.push_back(mk(1, 16'h1111, 0, 0, 0,          0, 0, 0,          1));
        tbl.push_back(mk(1, 16'h2222, 0, 1, 0,          0, 1, 0,          0));
        tbl.push_back(mk(0, 0,        0, 2, 0,          0, 2, 0,          0));
        tbl.push_back(mk(0, 0,        1, 2, 16'h1111,   0, 2, 0,          1));
        tbl.push_back(mk(0, 0,        1, 1, 16'h2222,   1, 2, 16'h1111,   1));
        tbl.push_back(mk(0, 0,        0, 0, 0,          1, 1, 16'h2222,   1));
        tbl.push_back(mk(0, 0,        0, 0, 0,          0, 0, 0,          1));
        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].orr;
            @(negedge clk);
            chk($sformatf("vec%0d_ov1", i), int'(out_valid_w[0]), int'(tbl[i].ov1));
            chk($sformatf("vec%0d_ov2", i), int'(out_valid_w[1]), int'(tbl[i].ov2));
            chk($sformatf("vec%0d_lvl1", i), int'(level_w[0]), tbl[i].l1);
            chk($sformatf("vec%0d_lvl2", i), int'(level_w[1]), tbl[i].l2);
            chk($sformatf("vec%0d_rd_n", i), int'(rd_n_w), tbl[i].rdn ? 3 : 0);
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready_w), 3);
            if (tbl[i].iv) chk($sformatf("vec%0d_we_n", i), int'(we_n_w), 0);
            if (tbl[i].ov1) chk($sformatf("vec%0d_d1", i), int'(out_data_w[0]), int'(tbl[i].d1));
            if (tbl[i].ov2) chk($sformatf("vec%0d_d2", i), int'(out_data_w[1]), int'(tbl[i].d2));
            cyc();
        end
        in_valid = 1'b0;

        // Fill with output stalled: RAM fills to 16, skid holds 2 / 3 more.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            cyc();
        end
        in_valid = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        chk("fill_level_rd1", int'(level_w[0]), 18);
        chk("fill_level_rd2", int'(level_w[1]), 19);
        chk("fill_in_ready", int'(in_ready_w), 0);
        chk("fill_out_valid", int'(out_valid_w), 3);
        chk("fill_head_rd1", int'(out_data_w[0]), 0);
`ifdef RF_FIFO_CTRL_ERR_CHK_EN
        chk("fill_err_ovf", int'(err_ovf_w), 3);
`endif
        cyc();
        drain("fill");

        // Flush with reads in flight and data in the skid; a push during flush is refused.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DW'(16'h0100 + i);
            cyc();
        end
        flush = 1'b1; in_data = 16'hDEAD;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_flush_level", int'(level_w), 0);
            chk("post_flush_out_valid", int'(out_valid_w), 0);
`ifdef RF_FIFO_CTRL_ERR_CHK_EN
            chk("post_flush_err_ovf", int'(err_ovf_w), 0);
`endif
            cyc();
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
        cyc();
        in_valid = 1'b0;
        seen[0] = 1'b0; seen[1] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++)
                if (out_valid_w[g] && !seen[g]) begin
                    chk($sformatf("post_flush_data[%0d]", g), int'(out_data_w[g]), 16'hBEEF);
                    seen[g] = 1'b1;
                end
            cyc();
        end
        chk("post_flush_seen", int'({seen[1], seen[0]}), 3);

        // Random streaming with stalls and rare flushes; pointer wraparound happens many times.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(99) == 0);
            cyc();
        end
        drain("random");

        // Reset mid-stream, then init must run again.
        out_ready = 1'b0;
        for (int n = 0; n < 12; n++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            cyc();
        end
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst_chk("midreset");
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        run_init();
        mon_en = 1'b1;
        in_valid = 1'b1; in_data = 16'h5A5A;
        cyc();
        in_valid = 1'b0;
        drain("after_reset");
`ifdef RF_FIFO_CTRL_ERR_CHK_EN
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("err_udf", int'(err_udf_w), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
